// File: rtl/pipe_regfile_scoreboard_if.sv
// Bundle between the decode/write-back stages and the register file scoreboard.
//   rd_addr/rd_data/rd_busy : NUM_RD packed read ports (port i at [i*W +: W])
//   wr_en/wr_addr/wr_data   : write-back port, also retires one pending producer
//   iss_valid/iss_addr      : decode registers a new producer; iss_ready accepts it
//   flush                   : drop every pending producer
//   any_busy                : some register still has a pending producer
// master = pipeline side, slave = register file.
interface pipe_regfile_scoreboard_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     flush;
  logic                     any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr, flush,
    input  rd_data, rd_busy, iss_ready, any_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr, flush,
    output rd_data, rd_busy, iss_ready, any_busy
  );
endinterface

// File: rtl/pipe_regfile_scoreboard.sv
// GPR file with r0 hardwired to zero, same-cycle write-to-read bypass and a
// per-register pending-write counter used for load-use stall detection.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset (clears registers and counters)
//   bus   : slave side of pipe_regfile_scoreboard_if (read, write-back, issue, flush)
module pipe_regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned MAX_PEND = 3
) (
  input logic                      clock,
  input logic                      reset,
  pipe_regfile_scoreboard_if.slave bus
);
  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam int unsigned CNT_W   = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] MaxPendC = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [CNT_W-1:0]  cnt_q  [NumRegs];
  logic [CNT_W-1:0]  cnt_d  [NumRegs];

  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_ready;
  logic                     iss_fire;
  logic                     any_busy;

  // Issue acceptance: a full counter still accepts if write-back frees a slot this cycle.
  logic [CNT_W-1:0] iss_cnt;
  logic             iss_wr_hit;
  assign iss_cnt    = cnt_q[bus.iss_addr];
  assign iss_wr_hit = bus.wr_en && (bus.wr_addr == bus.iss_addr);
  assign iss_ready  = reset || (bus.iss_addr == '0) || (iss_cnt < MaxPendC) ||
                      (iss_wr_hit && (iss_cnt != '0));
  assign iss_fire   = bus.iss_valid && iss_ready && !reset;

  // Scoreboard next state; r0 is never counted.
  always_comb begin
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < NumRegs; r++) begin
      logic inc;
      logic dec;
      inc = iss_fire && (bus.iss_addr == ADDR_W'(r));
      dec = bus.wr_en && (bus.wr_addr == ADDR_W'(r)) && (cnt_q[r] != '0);
      cnt_d[r] = cnt_q[r];
      if (bus.flush) begin
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + OneC;
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - OneC;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      if (bus.wr_en && (bus.wr_addr != '0)) begin
        regs_q[bus.wr_addr] <= bus.wr_data;
      end
      for (int unsigned r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Read ports: outputs are forced quiet while reset is held so nothing bypasses.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic              wr_hit;
    assign addr   = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign cnt    = cnt_q[addr];
    assign wr_hit = bus.wr_en && (bus.wr_addr == addr);

    assign rd_data[i*DATA_W +: DATA_W] = (reset || addr == '0) ? '0 :
                                         wr_hit                ? bus.wr_data :
                                                                 regs_q[addr];
    // The last outstanding producer retiring this cycle releases the reader immediately.
    assign rd_busy[i] = !reset && (addr != '0) && (cnt != '0) && !(wr_hit && cnt == OneC);
  end

  always_comb begin
    any_busy = 1'b0;
    for (int unsigned r = 1; r < NumRegs; r++) begin
      any_busy = any_busy | (cnt_q[r] != '0);
    end
    any_busy = any_busy && !reset;
  end

  assign bus.rd_data   = rd_data;
  assign bus.rd_busy   = rd_busy;
  assign bus.iss_ready = iss_ready;
  assign bus.any_busy  = any_busy;
endmodule
